// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and output vector layout for the MNIST input loader.
package mnist_pkg;

  localparam int unsigned NUM_FEAT = 62;
  localparam int unsigned DW       = 8;
  localparam int unsigned FEAT_W   = NUM_FEAT * DW;
  localparam int unsigned VEC_W    = 504;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CNT_W    = 16;

  localparam logic [DW-1:0]    BIAS_ONE = 8'h7F;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Bias byte sits above the feature bytes; feat[j] occupies bits [8j+7:8j].
  typedef struct packed {
    logic [DW-1:0]     bias;
    logic [FEAT_W-1:0] feat;
  } loader_vec_t;

endpackage

// File: rtl/loader_bank.sv
// Assembly buffer: NUM_FEAT x DW register file, single indexed byte write, flat parallel read.
module loader_bank
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DW-1:0]     wr_data,
  output logic [FEAT_W-1:0] rd_data
);

  logic [DW-1:0] mem [NUM_FEAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_FEAT); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_FEAT); i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) mem[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_FEAT); i++) rd_data[i*DW +: DW] = mem[i];
  end

endmodule

// File: rtl/mnist_input_loader.sv
// Byte-stream to 504-bit input vector loader with skid/assembly double buffering.
// Define LOADER_FRAME_CHECK_EN to enable s_last framing checks and frame_err.
module mnist_input_loader
  import mnist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  input  logic             vec_take,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e            state, state_d;
  logic [IDX_W-1:0]  wr_idx, wr_idx_d;
  logic [FEAT_W-1:0] feat_q, feat_d, bank_rd;
  logic [CNT_W-1:0]  frame_cnt_d;
  logic              vec_valid_d, frame_err_d, s_ready_d;
  logic              accept, at_last, out_free, frame_bad, bank_we;
  loader_vec_t       vec_s;

  assign accept   = s_valid && s_ready;
  assign at_last  = (wr_idx == LAST_IDX);
  assign out_free = !vec_valid || vec_take;

`ifdef LOADER_FRAME_CHECK_EN
  // Early s_last, or a full count without s_last, drops the frame.
  assign frame_bad = accept && (at_last ? !s_last : s_last);
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_bad     = 1'b0;
`endif

  loader_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_we),
    .wr_idx  (wr_idx),
    .wr_data (s_data),
    .rd_data (bank_rd)
  );

  always_comb begin
    state_d     = state;
    wr_idx_d    = wr_idx;
    feat_d      = feat_q;
    vec_valid_d = vec_valid;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt;
    bank_we     = 1'b0;

    if (vec_take) vec_valid_d = 1'b0;

    unique case (state)
      FILL: begin
        if (accept) begin
          if (frame_bad) begin
            wr_idx_d    = '0;
            frame_err_d = 1'b1;
          end else if (at_last) begin
            if (out_free) begin
              // Final byte bypasses the bank straight into the output register.
              feat_d      = {s_data, bank_rd[FEAT_W-DW-1:0]};
              vec_valid_d = 1'b1;
              frame_cnt_d = frame_cnt + CNT_W'(1);
              wr_idx_d    = '0;
            end else begin
              bank_we = 1'b1;
              state_d = HOLD;
            end
          end else begin
            bank_we  = 1'b1;
            wr_idx_d = wr_idx + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (vec_take) begin
          feat_d      = bank_rd;
          vec_valid_d = 1'b1;
          frame_cnt_d = frame_cnt + CNT_W'(1);
          wr_idx_d    = '0;
          state_d     = FILL;
        end
      end
    endcase

    s_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      s_ready   <= 1'b1;
      wr_idx    <= '0;
      feat_q    <= '0;
      vec_valid <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_d;
      s_ready   <= s_ready_d;
      wr_idx    <= wr_idx_d;
      feat_q    <= feat_d;
      vec_valid <= vec_valid_d;
      frame_err <= frame_err_d;
      frame_cnt <= frame_cnt_d;
    end
  end

  assign vec_s.bias = BIAS_ONE;
  assign vec_s.feat = feat_q;
  assign vec_out    = vec_s;

endmodule

// File: tb/tb_mnist_input_loader.sv
// Self-checking bench for mnist_input_loader: directed table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_mnist_input_loader;

  localparam int NF = 62;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_last = 1'b0;
  logic         vec_take = 1'b0;
  logic         s_ready, vec_valid, frame_err;
  logic [503:0] vec_out;
  logic [15:0]  frame_cnt;

  int checks = 0;
  int passed = 0;

  logic [7:0]   cur [NF];
  logic [495:0] exp_q [$];
  logic [15:0]  prev_cnt = 16'h0;
  logic [503:0] prev_vec = '0;
  bit           mon_en = 1'b0;
  bit           watch_valid = 1'b0;
  int           stable_viol = 0;
  int           valid_gaps = 0;

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  step;
    bit          take_last;
    logic        exp_valid;
    logic        exp_ready;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  mnist_input_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .vec_take  (vec_take),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  function automatic void fail(input string name);
    checks++;
    $display("FAIL %s: bound expired", name);
  endfunction

  function automatic void chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endfunction

  function automatic void chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void chk_v(input string name, input logic [503:0] act, input logic [503:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference image packing: byte j of the image lands at bits [8j+7:8j].
  function automatic logic [495:0] cur_feat();
    logic [495:0] v;
    for (int j = 0; j < NF; j++) v[j*8 +: 8] = cur[j];
    return v;
  endfunction

  function automatic logic [503:0] full_vec(input logic [495:0] f);
    return {8'h7F, f};
  endfunction

  // Delivery monitor: every frame_cnt step must present the next expected image.
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_cnt !== prev_cnt) begin
        chk_w("frame_cnt step", frame_cnt, 16'(prev_cnt + 16'd1));
        chk_b("vec_valid on load", vec_valid, 1'b1);
        if (exp_q.size() == 0) fail("unexpected delivery");
        else chk_v("delivered image", vec_out, full_vec(exp_q.pop_front()));
      end else if (vec_out !== prev_vec) begin
        stable_viol++;
      end
      if (watch_valid && !vec_valid) valid_gaps++;
    end
    prev_cnt = frame_cnt;
    prev_vec = vec_out;
  end

  task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
    waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (s_ready !== 1'b1) fail("s_ready wait");
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit take_last, input int gap_max,
                            input bit set_last, output int cyc);
    int w;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      if (take_last && i == n - 1) vec_take = 1'b1;
      send_byte(cur[i], set_last && (i == n - 1), w);
      cyc += w + 1;
    end
    if (take_last) vec_take = 1'b0;
  endtask

  task automatic pulse_take();
    vec_take = 1'b1;
    @(negedge clk);
    vec_take = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    logic [503:0] v1, v2;
    logic [15:0]  cnt0;
    bit           done;

    tbl[0] = '{8'h10, 8'h01, 1'b1, 1'b1, 1'b1, 16'd3};
    tbl[1] = '{8'h80, 8'h03, 1'b1, 1'b1, 1'b1, 16'd4};
    tbl[2] = '{8'hF0, 8'h07, 1'b1, 1'b1, 1'b1, 16'd5};
    tbl[3] = '{8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 16'd5};

    // Reset values
    repeat (2) @(negedge clk);
    chk_b("reset s_ready", s_ready, 1'b1);
    chk_b("reset vec_valid", vec_valid, 1'b0);
    chk_b("reset frame_err", frame_err, 1'b0);
    chk_w("reset frame_cnt", frame_cnt, 16'h0);
    chk_v("reset vec_out", vec_out, full_vec('0));
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Single frame 0x00..0x3D
    for (int i = 0; i < NF; i++) cur[i] = 8'(i);
    v1 = full_vec(cur_feat());
    exp_q.push_back(cur_feat());
    send_frame(NF, 1'b0, 0, 1'b1, cyc);
    chk_w("single cycles", 16'(cyc), 16'd62);
    chk_b("single vec_valid", vec_valid, 1'b1);
    chk_w("single byte0", 16'(vec_out[7:0]), 16'h00);
    chk_w("single byte61", 16'(vec_out[495:488]), 16'h3D);
    chk_w("single bias", 16'(vec_out[503:496]), 16'h7F);
    chk_w("single frame_cnt", frame_cnt, 16'd1);

    // Backpressure into HOLD
    for (int i = 0; i < NF; i++) cur[i] = 8'h A0 ^ 8'(i);
    v2 = full_vec(cur_feat());
    exp_q.push_back(cur_feat());
    send_frame(NF, 1'b0, 0, 1'b1, cyc);
    repeat (3) @(negedge clk);
    chk_b("hold s_ready", s_ready, 1'b0);
    chk_v("hold vec_out", vec_out, v1);
    chk_w("hold frame_cnt", frame_cnt, 16'd1);
    pulse_take();
    chk_v("release vec_out", vec_out, v2);
    chk_b("release s_ready", s_ready, 1'b1);
    chk_b("release vec_valid", vec_valid, 1'b1);
    chk_w("release frame_cnt", frame_cnt, 16'd2);

    // Take with nothing pending, then take while empty
    pulse_take();
    chk_b("drop vec_valid", vec_valid, 1'b0);
    chk_v("drop vec_out kept", vec_out, v2);
    pulse_take();
    chk_b("idle take vec_valid", vec_valid, 1'b0);
    chk_w("idle take frame_cnt", frame_cnt, 16'd2);

    // Back-to-back table
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NF; i++) cur[i] = 8'(int'(tbl[k].base) + int'(tbl[k].step) * i);
      exp_q.push_back(cur_feat());
      send_frame(NF, tbl[k].take_last, 0, 1'b1, cyc);
      chk_w("b2b cycles", 16'(cyc), 16'd62);
      chk_b("b2b vec_valid", vec_valid, tbl[k].exp_valid);
      chk_b("b2b s_ready", s_ready, tbl[k].exp_ready);
      chk_w("b2b frame_cnt", frame_cnt, tbl[k].exp_cnt);
      if (k == 0) watch_valid = 1'b1;
    end
    watch_valid = 1'b0;
    chk_w("b2b valid gaps", 16'(valid_gaps), 16'd0);
    pulse_take();
    chk_w("b2b hold drained", frame_cnt, 16'd6);
    chk_b("b2b s_ready back", s_ready, 1'b1);

    // Reset mid-frame with an image still valid
    for (int i = 0; i < 30; i++) send_byte(8'hC3, 1'b0, w);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_b("mid-rst s_ready", s_ready, 1'b1);
    chk_b("mid-rst vec_valid", vec_valid, 1'b0);
    chk_w("mid-rst frame_cnt", frame_cnt, 16'd0);
    chk_b("mid-rst frame_err", frame_err, 1'b0);
    chk_v("mid-rst vec_out", vec_out, full_vec('0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < NF; i++) cur[i] = 8'($urandom);
    v1 = full_vec(cur_feat());
    exp_q.push_back(cur_feat());
    send_frame(NF, 1'b0, 0, 1'b1, cyc);
    chk_v("post-rst vec_out", vec_out, v1);
    chk_w("post-rst frame_cnt", frame_cnt, 16'd1);

    // frame_cnt wrap
    pulse_take();
    mon_en = 1'b0;
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk_w("preload frame_cnt", frame_cnt, 16'hFFFF);
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < NF; i++) cur[i] = 8'($urandom);
    exp_q.push_back(cur_feat());
    send_frame(NF, 1'b0, 0, 1'b1, cyc);
    chk_w("wrap frame_cnt", frame_cnt, 16'h0000);

`ifdef LOADER_FRAME_CHECK_EN
    // Early s_last drops the partial frame
    for (int i = 0; i < NF; i++) cur[i] = 8'(8'h40 + i);
    send_frame(10, 1'b0, 0, 1'b1, cyc);
    chk_b("early last frame_err", frame_err, 1'b1);
    chk_w("early last frame_cnt", frame_cnt, 16'h0000);
    @(negedge clk);
    chk_b("frame_err one cycle", frame_err, 1'b0);
    exp_q.push_back(cur_feat());
    send_frame(NF, 1'b1, 0, 1'b1, cyc);
    chk_w("after early frame_cnt", frame_cnt, 16'd1);
    // Full count without s_last is dropped too
    for (int i = 0; i < NF; i++) cur[i] = 8'($urandom);
    send_frame(NF, 1'b1, 0, 1'b0, cyc);
    chk_b("no last frame_err", frame_err, 1'b1);
    chk_w("no last frame_cnt", frame_cnt, 16'd1);
    chk_b("no last s_ready", s_ready, 1'b1);
    @(negedge clk);
`endif

    // Randomized traffic: random gaps and random vec_take
    cnt0 = frame_cnt;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 12; f++) begin
          for (int i = 0; i < NF; i++) cur[i] = 8'($urandom);
          exp_q.push_back(cur_feat());
          send_frame(NF, 1'b0, 2, 1'b1, cyc);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          vec_take = ($urandom_range(0, 3) == 0);
        end
        vec_take = 1'b0;
      end
    join
    for (int k = 0; k < 8 && (exp_q.size() != 0 || vec_valid); k++) begin
      pulse_take();
      @(negedge clk);
    end
    chk_w("random drained", 16'(exp_q.size()), 16'd0);
    chk_b("random final valid", vec_valid, 1'b0);
    chk_w("random frame_cnt", frame_cnt, 16'(cnt0 + 16'd12));
    chk_w("vec_out stable between loads", 16'(stable_viol), 16'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
